llsc_link_ctrl: RTL and testbench
=================================

Name: llsc_link_ctrl

Overview:
- Drives the per-core link (LL/SC reservation) module from the datapath/cache side: sets the reservation on LL, checks it on SC, and gates the SC store.
- Broadcasts every completed local store to the other core, and turns incoming snoop writes into reservation invalidates.
- Sits between the datapath's dmem request lines and the dcache, beside the link module and the coherence bus.

Parameters:
- CPUID, 0, core index driven on bcast_src.

Ports:
- CLK  in  1  system clock
- nRST  in  1  asynchronous active-low reset
- dmemREN  in  1  datapath read request
- dmemWEN  in  1  datapath write request
- datomic  in  1  request is LL (with REN) or SC (with WEN)
- dmemaddr  in  32  request address (word_t)
- dhit  in  1  dcache access complete
- cache_ren  out  1  read enable to dcache
- cache_wen  out  1  gated write enable to dcache
- sc_done  out  1  one-cycle pulse: SC resolved
- sc_result  out  1  SC outcome (1 success, 0 fail), valid with sc_done
- lm_addr_cpu  out  32  address to link module (set/compare)
- lm_update  out  1  set-reservation pulse
- lm_addr_bus  out  32  invalidate address to link module
- lm_invalid  out  1  invalidate pulse
- lm_write_valid  in  1  reservation matches lm_addr_cpu
- snp_valid  in  1  remote store observed
- snp_addr  in  32  remote store address
- snp_ack  out  1  snoop consumed
- bcast_valid  out  1  local store broadcast request
- bcast_addr  out  32  broadcast address
- bcast_src  out  1  = CPUID
- bcast_ack  in  1  bus accepted broadcast

Behaviour:
- Reset: state IDLE; every output 0 except bcast_src = CPUID; snoop and own-clear pending flags cleared. Reset mid-operation abandons the transaction with no sc_done.
- Request address is registered (req_addr) on leaving IDLE; lm_addr_cpu = req_addr outside IDLE.
- FSM states: IDLE, LL_WAIT, LL_LINK, SC_CHECK, WRITE, BCAST, SC_FAIL.
- IDLE:
  - REN & !datomic: cache_ren = dmemREN (combinational pass-through); no state change.
  - REN & datomic: go to LL_WAIT.
  - WEN & !datomic: go to WRITE.
  - WEN & datomic: go to SC_CHECK.
  - REN and WEN together: WEN wins.
- LL_WAIT: cache_ren=1 until dhit, then LL_LINK.
- LL_LINK: lm_update=1 for exactly one cycle, then IDLE.
- SC_CHECK:
  - If lm_invalid is asserted this cycle, stall one cycle and do not sample.
  - Otherwise sample lm_write_valid: 1 goes to WRITE (SC flag kept), 0 goes to SC_FAIL.
- WRITE: cache_wen=1 until dhit, then BCAST.
- BCAST:
  - bcast_valid=1 and bcast_addr=req_addr, held stable until bcast_ack.
  - On ack: return to IDLE; if SC, pulse sc_done with sc_result=1 and set own_clear_pending.
- SC_FAIL: cache_wen stays 0; pulse sc_done with sc_result=0; set own_clear_pending; go to IDLE. Latency from entering SC_CHECK to sc_done is 2 cycles.
- Snoop path (independent of FSM):
  - snp_valid with no snoop pending: capture snp_addr.
  - Next cycle: lm_invalid=1, lm_addr_bus=captured, snp_ack=1, all for one cycle.
  - snp_valid while pending is held off (no ack) until the slot is free.
- Own clear:
  - When own_clear_pending is set and no snoop invalidate is in progress: lm_invalid=1 and lm_addr_bus=req_addr for one cycle, then clear the flag.
  - Snoop always wins; own clear is deferred, never dropped.
- A snoop to the reserved address arriving during SC_CHECK forces the stall above, so the SC sees the post-invalidate value and fails.
- lm_update and lm_invalid are never asserted in the same cycle; invalidate has priority, and LL_LINK holds one extra cycle if needed.

Decomposition:
- Shared cpu_types_pkg holds word_t and a new llsc_state_t enum (IDLE..SC_FAIL).
- One sub-module, llsc_snoop_slot: snoop capture, own-clear arbitration, and the lm_invalid/lm_addr_bus/snp_ack drive.

Test Plan:
- LL addr 0x100, dhit after 2 cycles -> lm_update pulses 1 cycle with lm_addr_cpu=0x100; cache_wen stays 0.
- LL 0x100 then SC 0x100, lm_write_valid=1, bcast_ack after 3 cycles -> cache_wen until dhit; bcast_addr=0x100; sc_done with sc_result=1; then lm_invalid, lm_addr_bus=0x100.
- SC 0x200 with lm_write_valid=0 -> no cache_wen; sc_done with sc_result=0 two cycles after SC_CHECK entry; own clear follows.
- LL 0x100, then snp_valid 0x100 in the same cycle SC enters SC_CHECK -> check stalls 1 cycle; lm_invalid with lm_addr_bus=0x100 precedes sample; SC fails.
- Plain store 0x300 -> bcast_valid held while bcast_ack=0 for 5 cycles; bcast_addr stable at 0x300; no sc_done.
- Assert nRST low while in BCAST -> all outputs 0 immediately; FSM IDLE; no sc_done after release.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: machine word and the LL/SC link-controller state encoding.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [2:0] {
        IDLE,
        LL_WAIT,
        LL_LINK,
        SC_CHECK,
        WRITE,
        BCAST,
        SC_FAIL
    } llsc_state_t;

endpackage

// File: rtl/llsc_snoop_slot.sv
// Single-entry snoop slot: turns remote stores and local SC completions into
// one-cycle reservation invalidates, with remote snoops taking priority.
module llsc_snoop_slot
    import cpu_types_pkg::*;
(
    input  logic  clk_i,
    input  logic  rst_ni,
    input  logic  snp_valid_i,
    input  word_t snp_addr_i,
    input  logic  own_set_i,
    input  word_t own_addr_i,
    output logic  lm_invalid_o,
    output word_t lm_addr_bus_o,
    output logic  snp_ack_o
);

    logic  inv_q, inv_d;
    logic  ack_q, ack_d;
    word_t addr_q, addr_d;
    logic  own_pend_q, own_pend_d;
    word_t own_addr_q, own_addr_d;

    always_comb begin
        inv_d      = 1'b0;
        ack_d      = 1'b0;
        addr_d     = addr_q;
        own_pend_d = own_pend_q;
        own_addr_d = own_addr_q;
        // ack_q marks the slot busy: a snoop seen during its own ack cycle is held off
        if (snp_valid_i && !ack_q) begin
            inv_d  = 1'b1;
            ack_d  = 1'b1;
            addr_d = snp_addr_i;
            if (own_set_i) begin
                own_pend_d = 1'b1;
                own_addr_d = own_addr_i;
            end
        end else if (own_pend_q) begin
            inv_d      = 1'b1;
            addr_d     = own_addr_q;
            own_pend_d = own_set_i;
            if (own_set_i) begin
                own_addr_d = own_addr_i;
            end
        end else if (own_set_i) begin
            inv_d  = 1'b1;
            addr_d = own_addr_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            inv_q      <= 1'b0;
            ack_q      <= 1'b0;
            addr_q     <= '0;
            own_pend_q <= 1'b0;
            own_addr_q <= '0;
        end else begin
            inv_q      <= inv_d;
            ack_q      <= ack_d;
            addr_q     <= addr_d;
            own_pend_q <= own_pend_d;
            own_addr_q <= own_addr_d;
        end
    end

    assign lm_invalid_o  = inv_q;
    assign lm_addr_bus_o = addr_q;
    assign snp_ack_o     = ack_q;

endmodule

// File: rtl/llsc_link_ctrl.sv
// LL/SC link controller: sequences LL reservation set, SC check/store/broadcast,
// and forwards snoop and own-clear invalidates to the per-core link module.
module llsc_link_ctrl
    import cpu_types_pkg::*;
#(
    parameter int CPUID = 0
) (
    input  logic  CLK,
    input  logic  nRST,
    input  logic  dmemREN,
    input  logic  dmemWEN,
    input  logic  datomic,
    input  word_t dmemaddr,
    input  logic  dhit,
    output logic  cache_ren,
    output logic  cache_wen,
    output logic  sc_done,
    output logic  sc_result,
    output word_t lm_addr_cpu,
    output logic  lm_update,
    output word_t lm_addr_bus,
    output logic  lm_invalid,
    input  logic  lm_write_valid,
    input  logic  snp_valid,
    input  word_t snp_addr,
    output logic  snp_ack,
    output logic  bcast_valid,
    output word_t bcast_addr,
    output logic  bcast_src,
    input  logic  bcast_ack
);

    llsc_state_t state_q;
    word_t       req_addr_q;
    logic        is_sc_q;
    logic        sc_done_q;
    logic        sc_result_q;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= IDLE;
            req_addr_q  <= '0;
            is_sc_q     <= 1'b0;
            sc_done_q   <= 1'b0;
            sc_result_q <= 1'b0;
        end else begin
            sc_done_q   <= 1'b0;
            sc_result_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (dmemWEN) begin
                        req_addr_q <= dmemaddr;
                        is_sc_q    <= datomic;
                        state_q    <= datomic ? SC_CHECK : WRITE;
                    end else if (dmemREN && datomic) begin
                        req_addr_q <= dmemaddr;
                        is_sc_q    <= 1'b0;
                        state_q    <= LL_WAIT;
                    end
                end
                LL_WAIT: if (dhit) state_q <= LL_LINK;
                // Reservation set waits out any invalidate so the two never collide
                LL_LINK: if (!lm_invalid) state_q <= IDLE;
                SC_CHECK: begin
                    if (!lm_invalid) begin
                        state_q <= lm_write_valid ? WRITE : SC_FAIL;
                    end
                end
                WRITE: if (dhit) state_q <= BCAST;
                BCAST: begin
                    if (bcast_ack) begin
                        state_q     <= IDLE;
                        sc_done_q   <= is_sc_q;
                        sc_result_q <= is_sc_q;
                    end
                end
                SC_FAIL: begin
                    state_q   <= IDLE;
                    sc_done_q <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // The completed SC's own clear is launched from the sc_done cycle
    llsc_snoop_slot u_snoop_slot (
        .clk_i         (CLK),
        .rst_ni        (nRST),
        .snp_valid_i   (snp_valid),
        .snp_addr_i    (snp_addr),
        .own_set_i     (sc_done_q),
        .own_addr_i    (req_addr_q),
        .lm_invalid_o  (lm_invalid),
        .lm_addr_bus_o (lm_addr_bus),
        .snp_ack_o     (snp_ack)
    );

    assign cache_ren   = ((state_q == IDLE) && dmemREN && !datomic && !dmemWEN)
                         || (state_q == LL_WAIT);
    assign cache_wen   = (state_q == WRITE);
    assign lm_update   = (state_q == LL_LINK) && !lm_invalid;
    assign lm_addr_cpu = (state_q == IDLE) ? '0 : req_addr_q;
    assign bcast_valid = (state_q == BCAST);
    assign bcast_addr  = (state_q == BCAST) ? req_addr_q : '0;
    assign bcast_src   = CPUID[0];
    assign sc_done     = sc_done_q;
    assign sc_result   = sc_result_q;

endmodule

// File: tb/tb_llsc_link_ctrl.sv
// Directed bench for llsc_link_ctrl with a behavioural link-module reservation model.
module tb_llsc_link_ctrl;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        dmemREN, dmemWEN, datomic, dhit;
    logic [31:0] dmemaddr;
    logic        cache_ren, cache_wen, sc_done, sc_result;
    logic [31:0] lm_addr_cpu, lm_addr_bus;
    logic        lm_update, lm_invalid, lm_write_valid;
    logic        snp_valid, snp_ack;
    logic [31:0] snp_addr;
    logic        bcast_valid, bcast_src, bcast_ack;
    logic [31:0] bcast_addr;

    int n_cmp = 0;
    int n_err = 0;

    logic        res_v;
    logic [31:0] res_addr;

    llsc_link_ctrl #(.CPUID(1)) dut (
        .CLK(CLK), .nRST(nRST),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN), .datomic(datomic), .dmemaddr(dmemaddr),
        .dhit(dhit),
        .cache_ren(cache_ren), .cache_wen(cache_wen),
        .sc_done(sc_done), .sc_result(sc_result),
        .lm_addr_cpu(lm_addr_cpu), .lm_update(lm_update),
        .lm_addr_bus(lm_addr_bus), .lm_invalid(lm_invalid),
        .lm_write_valid(lm_write_valid),
        .snp_valid(snp_valid), .snp_addr(snp_addr), .snp_ack(snp_ack),
        .bcast_valid(bcast_valid), .bcast_addr(bcast_addr), .bcast_src(bcast_src),
        .bcast_ack(bcast_ack)
    );

    always #5 CLK = ~CLK;

    // Link module stand-in: one reservation register
    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            res_v    <= 1'b0;
            res_addr <= '0;
        end else if (lm_invalid) begin
            if (lm_addr_bus == res_addr) res_v <= 1'b0;
        end else if (lm_update) begin
            res_v    <= 1'b1;
            res_addr <= lm_addr_cpu;
        end
    end
    assign lm_write_valid = res_v && (res_addr == lm_addr_cpu);

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_ll(input logic [31:0] a);
        dmemREN = 1; datomic = 1; dmemaddr = a;
        #1 chk("ll_idle_no_ren", cache_ren, 0);
        tick();
        dmemREN = 0; datomic = 0;
        chk("ll_wait_ren", cache_ren, 1);
        chk("ll_wait_addr", lm_addr_cpu, a);
        tick();
        chk("ll_wait_ren2", cache_ren, 1);
        dhit = 1;
        tick();
        dhit = 0;
        chk("ll_link_update", lm_update, 1);
        chk("ll_link_addr", lm_addr_cpu, a);
        chk("ll_link_no_wen", cache_wen, 0);
        tick();
        chk("ll_update_one_cycle", lm_update, 0);
    endtask

    initial begin
        nRST = 0; dmemREN = 0; dmemWEN = 0; datomic = 0; dmemaddr = '0; dhit = 0;
        snp_valid = 0; snp_addr = '0; bcast_ack = 0;
        #1;
        chk("rst_cache_ren", cache_ren, 0);
        chk("rst_cache_wen", cache_wen, 0);
        chk("rst_sc_done", sc_done, 0);
        chk("rst_lm_invalid", lm_invalid, 0);
        chk("rst_bcast_valid", bcast_valid, 0);
        chk("rst_bcast_src", bcast_src, 1);
        tick(); tick();
        nRST = 1;
        tick();

        // plain read pass-through
        dmemREN = 1; dmemaddr = 32'h80;
        #1 chk("plain_read_ren", cache_ren, 1);
        dmemWEN = 1;
        #1 chk("ren_wen_wen_wins", cache_ren, 0);
        dmemWEN = 0; dmemREN = 0;
        tick();

        // LL 0x100 then successful SC
        do_ll(32'h100);
        dmemWEN = 1; datomic = 1; dmemaddr = 32'h100;
        tick();
        dmemWEN = 0; datomic = 0;
        chk("sc_check_no_wen", cache_wen, 0);
        tick();
        chk("sc_write_wen", cache_wen, 1);
        dhit = 1;
        tick();
        dhit = 0;
        chk("sc_bcast_valid", bcast_valid, 1);
        chk("sc_bcast_addr", bcast_addr, 32'h100);
        chk("sc_bcast_no_wen", cache_wen, 0);
        tick(); tick();
        bcast_ack = 1;
        tick();
        bcast_ack = 0;
        chk("sc_ok_done", sc_done, 1);
        chk("sc_ok_result", sc_result, 1);
        chk("sc_ok_bcast_drop", bcast_valid, 0);
        tick();
        chk("sc_ok_done_pulse", sc_done, 0);
        chk("sc_ok_own_inv", lm_invalid, 1);
        chk("sc_ok_own_addr", lm_addr_bus, 32'h100);
        chk("sc_ok_own_no_ack", snp_ack, 0);
        tick();
        chk("sc_ok_own_inv_one", lm_invalid, 0);

        // SC 0x200 without a reservation
        dmemWEN = 1; datomic = 1; dmemaddr = 32'h200;
        tick();
        dmemWEN = 0; datomic = 0;
        chk("scf_check_no_wen", cache_wen, 0);
        chk("scf_check_no_done", sc_done, 0);
        tick();
        chk("scf_fail_no_wen", cache_wen, 0);
        chk("scf_fail_no_done", sc_done, 0);
        tick();
        chk("scf_done", sc_done, 1);
        chk("scf_result", sc_result, 0);
        tick();
        chk("scf_own_inv", lm_invalid, 1);
        chk("scf_own_addr", lm_addr_bus, 32'h200);
        tick();
        chk("scf_own_inv_one", lm_invalid, 0);

        // LL 0x100, then SC racing a snoop to the same address
        do_ll(32'h100);
        dmemWEN = 1; datomic = 1; dmemaddr = 32'h100;
        snp_valid = 1; snp_addr = 32'h100;
        tick();
        dmemWEN = 0; datomic = 0; snp_valid = 0;
        chk("race_snp_inv", lm_invalid, 1);
        chk("race_snp_addr", lm_addr_bus, 32'h100);
        chk("race_snp_ack", snp_ack, 1);
        chk("race_stall_no_wen", cache_wen, 0);
        tick();
        chk("race_inv_done", lm_invalid, 0);
        chk("race_still_no_wen", cache_wen, 0);
        tick();
        chk("race_fail_no_wen", cache_wen, 0);
        chk("race_fail_no_done", sc_done, 0);
        tick();
        chk("race_done", sc_done, 1);
        chk("race_result", sc_result, 0);
        tick();
        chk("race_own_inv", lm_invalid, 1);
        tick();

        // snoop held off while the slot is busy
        snp_valid = 1; snp_addr = 32'h700;
        tick();
        chk("snp1_inv", lm_invalid, 1);
        chk("snp1_addr", lm_addr_bus, 32'h700);
        chk("snp1_ack", snp_ack, 1);
        snp_addr = 32'h704;
        tick();
        chk("snp2_held_ack", snp_ack, 0);
        chk("snp2_held_inv", lm_invalid, 0);
        tick();
        snp_valid = 0;
        chk("snp2_ack", snp_ack, 1);
        chk("snp2_addr", lm_addr_bus, 32'h704);
        tick();
        chk("snp2_ack_one", snp_ack, 0);

        // plain store with a slow broadcast ack
        dmemWEN = 1; dmemaddr = 32'h300;
        tick();
        dmemWEN = 0;
        chk("st_wen", cache_wen, 1);
        dhit = 1;
        tick();
        dhit = 0;
        for (int i = 0; i < 5; i++) begin
            chk("st_bcast_hold", bcast_valid, 1);
            chk("st_bcast_addr", bcast_addr, 32'h300);
            chk("st_no_done", sc_done, 0);
            if (i < 4) tick();
        end
        bcast_ack = 1;
        tick();
        bcast_ack = 0;
        chk("st_no_sc_done", sc_done, 0);
        chk("st_bcast_drop", bcast_valid, 0);
        tick();
        chk("st_no_own_clear", lm_invalid, 0);

        // reset asserted mid-broadcast of an SC
        do_ll(32'h500);
        dmemWEN = 1; datomic = 1; dmemaddr = 32'h500;
        tick();
        dmemWEN = 0; datomic = 0;
        tick();
        dhit = 1;
        tick();
        dhit = 0;
        chk("rb_bcast_valid", bcast_valid, 1);
        #2 nRST = 0;
        #1;
        chk("rb_bcast_valid0", bcast_valid, 0);
        chk("rb_bcast_addr0", bcast_addr, 0);
        chk("rb_cache_wen0", cache_wen, 0);
        chk("rb_lm_addr_cpu0", lm_addr_cpu, 0);
        chk("rb_bcast_src", bcast_src, 1);
        bcast_ack = 1;
        tick();
        tick();
        nRST = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rb_no_sc_done", sc_done, 0);
            chk("rb_no_inv", lm_invalid, 0);
            chk("rb_idle_no_bcast", bcast_valid, 0);
        end
        bcast_ack = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
